mac_feeder: RTL and testbench
=============================

# mac_feeder

Operand sequencer for the MAC datapath. It takes a stream of (A, B) operand pairs over a valid/ready handshake and splits it into dot-product segments. For each segment it drives one clear followed by one enable pulse per pair into a MAC. It then waits for the accumulator to settle and returns the result over a valid/ready output handshake.

## Interface
- DATA_WIDTH, 8, operand width
- LEN, 8, max pairs per segment
- ACC_WIDTH, 3*DATA_WIDTH, accumulator width; design-time requirement LEN*(2^DATA_WIDTH-1)^2 < 2^ACC_WIDTH
- MAC_LAT, 1, cycles from the cycle mac_en is high until mac_cout reflects it
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  feeder accepts pair
- in_a  in  DATA_WIDTH  operand A
- in_b  in  DATA_WIDTH  operand B
- in_last  in  1  final pair of segment
- mac_en  out  1  MAC accumulate enable
- mac_clr  out  1  MAC clear
- mac_a  out  DATA_WIDTH  MAC operand A
- mac_b  out  DATA_WIDTH  MAC operand B
- mac_cout  in  ACC_WIDTH  MAC accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_WIDTH  dot-product result
- out_count  out  $clog2(LEN+1)  pairs in segment

## Operation
- FSM states: IDLE, CLR, STREAM, DRAIN, RESULT.
- **IDLE**
  - in_ready=0.
  - in_valid=1 moves to CLR. The pair is not consumed here.
- **CLR**
  - Exactly one cycle.
  - mac_clr=1, in_ready=0, beat counter reset to 0.
  - Moves to STREAM.
- **STREAM**
  - in_ready=1.
  - Each handshake (in_valid & in_ready) registers in_a/in_b onto mac_a/mac_b, pulses mac_en=1 for the next cycle, and increments the counter.
  - Gaps in in_valid are allowed; mac_en=0 during a gap and mac_a/mac_b hold.
  - Moves to DRAIN when the accepted pair has in_last=1, or when the counter reaches LEN (truncation), whichever comes first.
  - After truncation, following pairs start a new segment.
- **DRAIN**
  - in_ready=0.
  - Lasts MAC_LAT+1 cycles.
  - On the last DRAIN cycle, out_data<=mac_cout and out_count<=counter.
  - Moves to RESULT.
- **RESULT**
  - out_valid=1; out_data and out_count stable.
  - out_valid & out_ready moves to IDLE.
- No arithmetic in the feeder. out_data is mac_cout unmodified, with no saturation and no overflow detection.

## Timing
- Reset values: in_ready=0, mac_en=0, mac_clr=0, mac_a=0, mac_b=0, out_valid=0, out_data=0, out_count=0, state IDLE.
- in_valid first seen high in IDLE at cycle t:
  - mac_clr high at t+1.
  - First pair accepted at t+2.
  - mac_en high at t+3.
- Single-pair segment:
  - DRAIN spans t+3..t+3+MAC_LAT.
  - out_valid first high at t+4+MAC_LAT (t+5 at default).
- Segment of N pairs with no gaps: out_valid rises N+MAC_LAT+3 cycles after the IDLE detect.
- out_ready low: RESULT holds indefinitely with no change to outputs.
- Back-to-back segments: one IDLE cycle after the result handshake, then CLR.
- rst high in any state: the next cycle is the full reset state. Any partial segment is discarded and no out_valid is produced. No mac_clr is issued on reset; the MAC has its own reset.
- in_last=1 on the LEN-th pair: normal end with out_count=LEN.

## Configuration
- `MAC_FEEDER_PERF_EN`
  - Defined: adds output busy_cycles, 32 bits. It counts cycles with state≠IDLE, wraps at 2^32, and is cleared only by rst.
  - Undefined: port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package mac_feeder_pkg holds:
  - the state enum type (IDLE, CLR, STREAM, DRAIN, RESULT);
  - default DATA_WIDTH/LEN/MAC_LAT localparams;
  - an ACC_WIDTH helper function.
- Single module; no sub-module. The drain counter and beat counter stay inline.
- The bench pairs mac_feeder with the existing MAC (DATA_WIDTH=8, 24-bit Cout).

## Test plan
- Pair (3,4) with in_last -> one mac_clr, one mac_en; out_data=0x00000C, out_count=1; out_valid at t+5.
- Pairs (3,4),(5,6), in_last on the second -> out_data=0x00002A, out_count=2.
- Pair (0xFF,0xFF) with in_last -> out_data=0x00FE01.
- Four (10,10) pairs with 1-cycle gaps between them, in_last on the fourth, out_ready held low 5 cycles -> out_data=0x000190, out_count=4; outputs stable while stalled; exactly 4 mac_en pulses.
- LEN=4, six (7,8) pairs with no in_last -> first result 0x0000E0 count 4; mac_clr precedes the 5th pair.
- rst asserted after 2 of 3 accepted pairs -> all outputs 0 next cycle; no out_valid; a new segment (2,2)+last then yields 0x000004.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// Shared types and defaults for the MAC operand feeder.
package mac_feeder_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN        = 8;
    localparam int DEF_MAC_LAT    = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    // Wide enough for LEN products of full-scale operands at default sizes.
    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_feeder.sv
// Splits an operand-pair stream into dot-product segments and drives a MAC.
// Optional MAC_FEEDER_PERF_EN adds a 32-bit busy-cycle counter output.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN        = DEF_LEN,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
    parameter int MAC_LAT    = DEF_MAC_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    input  logic                      in_last,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]     mac_b,
    input  logic [ACC_WIDTH-1:0]      mac_cout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic [$clog2(LEN+1)-1:0]  out_count
`ifdef MAC_FEEDER_PERF_EN
    ,
    output logic [31:0]               busy_cycles
`endif
);

    localparam int CW  = $clog2(LEN + 1);
    localparam int DCW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [DCW-1:0] drain;
    logic           hs;
    logic           drain_last;

    assign hs         = in_valid & in_ready;
    assign drain_last = (drain == DCW'(MAC_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        mac_clr   = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) state_n = CLR;
            end
            CLR: begin
                mac_clr = 1'b1;
                state_n = STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                // Segment ends on in_last or on reaching LEN pairs.
                if (in_valid && (in_last || cnt == CW'(LEN - 1)))
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_n = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            cnt       <= '0;
            drain     <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            mac_en <= hs;
            if (hs) begin
                mac_a <= in_a;
                mac_b <= in_b;
                cnt   <= cnt + 1'b1;
            end
            if (state == CLR) cnt <= '0;
            if (state == DRAIN) begin
                drain <= drain + 1'b1;
            end else begin
                drain <= '0;
            end
            // Accumulator has settled by the final drain cycle.
            if (state == DRAIN && drain_last) begin
                out_data  <= mac_cout;
                out_count <= cnt;
            end
        end
    end

`ifdef MAC_FEEDER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (state != IDLE) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural 1-cycle-latency MAC.
module tb_mac_feeder;

    localparam int DW  = 8;
    localparam int LEN = 4;
    localparam int LAT = 1;
    localparam int AW  = 24;
    localparam int CW  = $clog2(LEN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_last = 1'b0;
    logic          mac_en;
    logic          mac_clr;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_cout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;
`ifdef MAC_FEEDER_PERF_EN
    logic [31:0]   busy_cycles;
`endif

    mac_feeder #(
        .DATA_WIDTH(DW),
        .LEN(LEN),
        .ACC_WIDTH(AW),
        .MAC_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_last(in_last),
        .mac_en(mac_en),
        .mac_clr(mac_clr),
        .mac_a(mac_a),
        .mac_b(mac_b),
        .mac_cout(mac_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count)
`ifdef MAC_FEEDER_PERF_EN
        ,
        .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_cout <= '0;
        end else if (mac_clr) begin
            mac_cout <= '0;
        end else if (mac_en) begin
            mac_cout <= mac_cout + AW'(mac_a) * AW'(mac_b);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            en_cnt = 0;
    int            clr_cnt = 0;
    int            clr_cyc = -1;
    int            vld_cnt = 0;
    int            rise_cyc = -1;
    logic          prev_v = 1'b0;
    logic [AW-1:0] rq_d[$];
    logic [CW-1:0] rq_c[$];

    always @(negedge clk) begin
        if (mac_en === 1'b1) en_cnt++;
        if (mac_clr === 1'b1) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (out_valid === 1'b1) vld_cnt++;
        if (out_valid === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
        prev_v = out_valid;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            rq_d.push_back(out_data);
            rq_c.push_back(out_count);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic last, output int acc);
        int n;
        n = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("accept_timeout", 32'(in_ready), 32'd1);
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input logic [AW-1:0] ed, input logic [CW-1:0] ec,
                               input string tag);
        int n;
        n = 0;
        while (rq_d.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_present"}, 32'(rq_d.size() > 0), 32'd1);
        if (rq_d.size() > 0) begin
            chk({tag, "_data"}, 32'(rq_d.pop_front()), 32'(ed));
            chk({tag, "_count"}, 32'(rq_c.pop_front()), 32'(ec));
        end
    endtask

    initial begin
        int t0, e0, c0, v0, acc, n;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd0);
        chk("rst_mac_a", 32'(mac_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single pair (3,4)
        e0 = en_cnt;
        c0 = clr_cnt;
        t0 = cyc;
        send(8'd3, 8'd4, 1'b1, acc);
        chk("t1_accept_cyc", 32'(acc - t0), 32'd2);
        wait_result(24'h00000C, CW'(1), "t1");
        chk("t1_valid_lat", 32'(rise_cyc - t0), 32'd5);
        chk("t1_en_pulses", 32'(en_cnt - e0), 32'd1);
        chk("t1_clr_pulses", 32'(clr_cnt - c0), 32'd1);
        repeat (2) @(negedge clk);

        // two pairs
        t0 = cyc;
        send(8'd3, 8'd4, 1'b0, acc);
        send(8'd5, 8'd6, 1'b1, acc);
        wait_result(24'h00002A, CW'(2), "t2");
        chk("t2_valid_lat", 32'(rise_cyc - t0), 32'd6);
        repeat (2) @(negedge clk);

        // full-scale operands
        send(8'hFF, 8'hFF, 1'b1, acc);
        wait_result(24'h00FE01, CW'(1), "t3");
        repeat (2) @(negedge clk);

        // gapped stream, last on the LEN-th pair, stalled consumer
        out_ready = 1'b0;
        e0 = en_cnt;
        for (int i = 0; i < 4; i++) begin
            send(8'd10, 8'd10, i == 3, acc);
            if (i < 3) @(negedge clk);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_data", 32'(out_data), 32'h190);
            chk("t4_stall_count", 32'(out_count), 32'd4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_result(24'h000190, CW'(4), "t4");
        chk("t4_en_pulses", 32'(en_cnt - e0), 32'd4);
        repeat (2) @(negedge clk);

        // truncation at LEN
        for (int i = 0; i < 4; i++) send(8'd7, 8'd8, 1'b0, acc);
        send(8'd7, 8'd8, 1'b0, acc);
        chk("t5_clr_before_5th", 32'(acc - clr_cyc), 32'd1);
        send(8'd7, 8'd8, 1'b0, acc);
        wait_result(24'h0000E0, CW'(4), "t5");
        @(negedge clk);
        chk("t5_no_early_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset mid-segment
        send(8'd9, 8'd9, 1'b0, acc);
        send(8'd9, 8'd9, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_mac_en", 32'(mac_en), 32'd0);
        chk("t6_mac_clr", 32'(mac_clr), 32'd0);
        chk("t6_mac_a", 32'(mac_a), 32'd0);
        chk("t6_mac_b", 32'(mac_b), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_data", 32'(out_data), 32'd0);
        chk("t6_out_count", 32'(out_count), 32'd0);
        v0 = vld_cnt;
        repeat (8) @(negedge clk);
        chk("t6_no_valid", 32'(vld_cnt - v0), 32'd0);
        send(8'd2, 8'd2, 1'b1, acc);
        wait_result(24'h000004, CW'(1), "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
